test_monitor: RTL and testbench
===============================

TEST_MONITOR -- requirements
Module: test_monitor

Interface
REQ-001 SHALL have parameter N_HARTS, default 1, number of monitored store ports (1..8).
REQ-002 SHALL have parameter XLEN, default 32, address/data width.
REQ-003 SHALL have parameter TOHOST_ADDR, default 32'h8000_1000, byte address of the tohost word.
REQ-004 SHALL have parameter TIMEOUT, default 100000, watchdog limit in cycles (>=2).
REQ-005 SHALL have parameter CYCLE_W, default 32, cycle counter width.
REQ-006 SHALL have port i_clk  in  1  single clock; all state changes on rising edge.
REQ-007 SHALL have port i_rst_n  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port i_start  in  1  start/restart a test run.
REQ-009 SHALL have port i_wr_en  in  N_HARTS  per-hart store strobe.
REQ-010 SHALL have port i_wr_addr  in  N_HARTS*XLEN  per-hart store address; hart h uses bits [h*XLEN +: XLEN].
REQ-011 SHALL have port i_wr_data  in  N_HARTS*XLEN  per-hart store data, packed as i_wr_addr.
REQ-012 SHALL have port o_busy  out  1  high in RUN.
REQ-013 SHALL have port o_done  out  1  high in DONE.
REQ-014 SHALL have port o_pass  out  1  valid when o_done; all harts passed.
REQ-015 SHALL have port o_timeout  out  1  valid when o_done; run ended by watchdog.
REQ-016 SHALL have port o_fail_hart  out  max(1,$clog2(N_HARTS))  index of the failing hart.
REQ-017 SHALL have port o_fail_code  out  XLEN-1  failing test number (data>>1).
REQ-018 SHALL have port o_hart_done  out  N_HARTS  per-hart "reported" flags.
REQ-019 SHALL have port o_cycles  out  CYCLE_W  cycles spent in RUN.

Function
REQ-020 SHALL implement FSM IDLE, RUN, DONE; IDLE->RUN on i_start; DONE->RUN on i_start; RUN ignores i_start.
REQ-021 SHALL clear o_hart_done, o_pass, o_timeout, o_fail_hart, o_fail_code and o_cycles on every entry to RUN.
REQ-022 SHALL treat a write as qualifying only in RUN, with i_wr_en[h]=1, addr==TOHOST_ADDR, data[0]=1 and o_hart_done[h]=0; all other writes are ignored, including writes in the i_start cycle.
REQ-023 SHALL set o_hart_done[h] on a qualifying write; data==1 means pass, any other odd value means fail with code data[XLEN-1:1].
REQ-024 SHALL go RUN->DONE on the edge sampling the first failing write; o_pass=0, fail fields latched; o_done is visible the next cycle.
REQ-025 SHALL go RUN->DONE with o_pass=1 on the edge at which every hart has reported pass.
REQ-026 SHALL latch the lowest hart index when several harts fail in the same cycle.
REQ-027 SHALL increment o_cycles once per RUN cycle, saturate at all-ones and hold in DONE.
REQ-028 SHALL hold all outputs stable in DONE until the next i_start.

Reset
REQ-029 SHALL, while i_rst_n=0, immediately force IDLE and zero every output and internal register, regardless of the clock.
REQ-030 SHALL abandon a run in progress on reset; results are not retained.

Configuration
REQ-031 SHALL, when macro TEST_MONITOR_WATCHDOG_EN is defined, go RUN->DONE with o_timeout=1 and o_pass=0 when o_cycles reaches TIMEOUT without completion; a qualifying write in that same cycle takes priority over the timeout.
REQ-032 SHALL, when TEST_MONITOR_WATCHDOG_EN is undefined, have no watchdog logic; o_timeout is tied to 0 and RUN ends only through REQ-024/025.

Verification
REQ-033 SHALL cover: N_HARTS=1, start, write 1 to TOHOST_ADDR at cycle 10 -> o_done=1 and o_pass=1 next cycle, o_cycles=10.
REQ-034 SHALL cover: N_HARTS=2, hart1 writes 32'h7 -> DONE, o_pass=0, o_fail_hart=1, o_fail_code=3; a later hart0 write does not change the result.
REQ-035 SHALL cover: N_HARTS=4, harts 2 and 3 fail in the same cycle -> o_fail_hart=2.
REQ-036 SHALL cover: writes of 32'h2 to TOHOST_ADDR, 1 to TOHOST_ADDR+4, and 1 in IDLE -> no effect, o_busy stays as it was.
REQ-037 SHALL cover: TEST_MONITOR_WATCHDOG_EN defined, TIMEOUT=50, no writes -> o_done=1 and o_timeout=1 with o_cycles=50; macro undefined -> still busy at cycle 1000.
REQ-038 SHALL cover: i_rst_n pulsed low mid-RUN between clock edges -> outputs zero at once, IDLE; a new i_start runs normally.

Source files
------------

// File: rtl/test_monitor.sv
// test_monitor: watches per-hart stores to the tohost word and reports the test outcome.
// A store of 1 means the hart passed; any other odd value is a failure with code data>>1.
// Optional watchdog: define TEST_MONITOR_WATCHDOG_EN to end a run after TIMEOUT cycles.
`timescale 1ns/1ps

module test_monitor #(
  parameter int unsigned     N_HARTS     = 1,
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h8000_1000,
  parameter int unsigned     TIMEOUT     = 100000,
  parameter int unsigned     CYCLE_W     = 32,
  localparam int unsigned    HartW       = (N_HARTS > 1) ? $clog2(N_HARTS) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [N_HARTS-1:0]      i_wr_en,
  input  logic [N_HARTS*XLEN-1:0] i_wr_addr,
  input  logic [N_HARTS*XLEN-1:0] i_wr_data,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_pass,
  output logic                    o_timeout,
  output logic [HartW-1:0]        o_fail_hart,
  output logic [XLEN-2:0]         o_fail_code,
  output logic [N_HARTS-1:0]      o_hart_done,
  output logic [CYCLE_W-1:0]      o_cycles
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q;
  logic                 busy_q, done_q, pass_q;
  logic [HartW-1:0]     fail_hart_q;
  logic [XLEN-2:0]      fail_code_q;
  logic [N_HARTS-1:0]   hart_done_q;
  logic [CYCLE_W-1:0]   cycles_q;

  logic [N_HARTS-1:0]   qual, pass_wr, fail_wr;
  logic [XLEN-1:0]      addr_h, data_h;
  logic [HartW-1:0]     fail_idx;
  logic [XLEN-2:0]      fail_code_sel;
  logic                 any_fail, all_pass;
  logic [CYCLE_W-1:0]   cycles_inc;

  // Decode qualifying stores; the downward scan leaves the lowest failing hart selected.
  always_comb begin
    qual          = '0;
    pass_wr       = '0;
    fail_wr       = '0;
    addr_h        = '0;
    data_h        = '0;
    fail_idx      = '0;
    fail_code_sel = '0;
    for (int h = N_HARTS - 1; h >= 0; h--) begin
      addr_h     = i_wr_addr[h*XLEN +: XLEN];
      data_h     = i_wr_data[h*XLEN +: XLEN];
      qual[h]    = (state_q == StRun) && i_wr_en[h] && (addr_h == TOHOST_ADDR) &&
                   data_h[0] && !hart_done_q[h];
      pass_wr[h] = qual[h] && (data_h == XLEN'(1));
      fail_wr[h] = qual[h] && (data_h != XLEN'(1));
      if (fail_wr[h]) begin
        fail_idx      = HartW'(h);
        fail_code_sel = data_h[XLEN-1:1];
      end
    end
    any_fail   = |fail_wr;
    // A hart already marked done must have passed, otherwise the run would have ended.
    all_pass   = &(hart_done_q | pass_wr);
    cycles_inc = (&cycles_q) ? cycles_q : cycles_q + CYCLE_W'(1);
  end

`ifdef TEST_MONITOR_WATCHDOG_EN
  logic timeout_q;
  logic timeout_hit;

  // Watchdog fires on the edge that would bring the cycle count to TIMEOUT.
  always_comb begin
    timeout_hit = (cycles_inc == CYCLE_W'(TIMEOUT));
  end

  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  // Run-control FSM with all result outputs registered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_hart_q <= '0;
      fail_code_q <= '0;
      hart_done_q <= '0;
      cycles_q    <= '0;
`ifdef TEST_MONITOR_WATCHDOG_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          // Every (re)start wipes the previous result.
          if (i_start) begin
            state_q     <= StRun;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_hart_q <= '0;
            fail_code_q <= '0;
            hart_done_q <= '0;
            cycles_q    <= '0;
`ifdef TEST_MONITOR_WATCHDOG_EN
            timeout_q   <= 1'b0;
`endif
          end
        end
        StRun: begin
          cycles_q    <= cycles_inc;
          hart_done_q <= hart_done_q | qual;
          if (any_fail) begin
            state_q     <= StDone;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            pass_q      <= 1'b0;
            fail_hart_q <= fail_idx;
            fail_code_q <= fail_code_sel;
          end else if (all_pass) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= 1'b1;
          end
`ifdef TEST_MONITOR_WATCHDOG_EN
          else if (timeout_hit) begin
            state_q   <= StDone;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            pass_q    <= 1'b0;
            timeout_q <= 1'b1;
          end
`endif
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_pass      = pass_q;
  assign o_fail_hart = fail_hart_q;
  assign o_fail_code = fail_code_q;
  assign o_hart_done = hart_done_q;
  assign o_cycles    = cycles_q;

endmodule

// File: tb/tb_test_monitor.sv
// Directed bench for test_monitor: three instances (1, 2 and 4 harts) share clock and reset.
`timescale 1ns/1ps

module tb_test_monitor;

  localparam logic [31:0] TH = 32'h8000_1000;

  int tests_run    = 0;
  int tests_failed = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 1-hart instance
  logic        start1;
  logic [0:0]  wr_en1;
  logic [31:0] addr1, data1;
  logic        busy1, done1, pass1, to1;
  logic [0:0]  fh1;
  logic [30:0] fc1;
  logic [0:0]  hd1;
  logic [31:0] cyc1;

  // 2-hart instance
  logic        start2;
  logic [1:0]  wr_en2;
  logic [63:0] addr2, data2;
  logic        busy2, done2, pass2, to2;
  logic [0:0]  fh2;
  logic [30:0] fc2;
  logic [1:0]  hd2;
  logic [31:0] cyc2;

  // 4-hart instance, short watchdog
  logic         start4;
  logic [3:0]   wr_en4;
  logic [127:0] addr4, data4;
  logic         busy4, done4, pass4, to4;
  logic [1:0]   fh4;
  logic [30:0]  fc4;
  logic [3:0]   hd4;
  logic [31:0]  cyc4;

  test_monitor #(.N_HARTS(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_wr_en(wr_en1),
    .i_wr_addr(addr1), .i_wr_data(data1), .o_busy(busy1), .o_done(done1),
    .o_pass(pass1), .o_timeout(to1), .o_fail_hart(fh1), .o_fail_code(fc1),
    .o_hart_done(hd1), .o_cycles(cyc1)
  );

  test_monitor #(.N_HARTS(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_wr_en(wr_en2),
    .i_wr_addr(addr2), .i_wr_data(data2), .o_busy(busy2), .o_done(done2),
    .o_pass(pass2), .o_timeout(to2), .o_fail_hart(fh2), .o_fail_code(fc2),
    .o_hart_done(hd2), .o_cycles(cyc2)
  );

  test_monitor #(.N_HARTS(4), .TIMEOUT(50)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .i_wr_en(wr_en4),
    .i_wr_addr(addr4), .i_wr_data(data4), .o_busy(busy4), .o_done(done4),
    .o_pass(pass4), .o_timeout(to4), .o_fail_hart(fh4), .o_fail_code(fc4),
    .o_hart_done(hd4), .o_cycles(cyc4)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start1 = 0; wr_en1 = '0; addr1 = '0; data1 = '0;
    start2 = 0; wr_en2 = '0; addr2 = '0; data2 = '0;
    start4 = 0; wr_en4 = '0; addr4 = '0; data4 = '0;
    tick(); tick();
    tests_run++; if ({busy1, done1, pass1, to1} !== 4'b0) begin tests_failed++;
      $display("FAIL reset_flags1: got %b want 0000", {busy1, done1, pass1, to1}); end
    tests_run++; if (cyc1 !== 32'd0) begin tests_failed++;
      $display("FAIL reset_cycles1: got %0d want 0", cyc1); end
    tests_run++; if ({busy4, done4, hd4, fh4, fc4} !== '0) begin tests_failed++;
      $display("FAIL reset_dut4: got busy=%b done=%b hd=%b fh=%0d fc=%0d want all 0",
               busy4, done4, hd4, fh4, fc4); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_pass();
    start1 = 1; tick(); start1 = 0;
    tests_run++; if (busy1 !== 1'b1 || cyc1 !== 32'd0) begin tests_failed++;
      $display("FAIL start1: got busy=%b cyc=%0d want busy=1 cyc=0", busy1, cyc1); end
    repeat (9) tick();
    tests_run++; if (cyc1 !== 32'd9 || done1 !== 1'b0) begin tests_failed++;
      $display("FAIL run1_cycles: got cyc=%0d done=%b want cyc=9 done=0", cyc1, done1); end
    wr_en1 = 1; addr1 = TH; data1 = 32'h1; tick(); wr_en1 = 0;
    tests_run++; if ({done1, pass1, busy1, to1, hd1} !== 5'b11001) begin tests_failed++;
      $display("FAIL pass1_flags: got done,pass,busy,to,hd=%b want 11001",
               {done1, pass1, busy1, to1, hd1}); end
    tests_run++; if (cyc1 !== 32'd10) begin tests_failed++;
      $display("FAIL pass1_cycles: got %0d want 10", cyc1); end
    repeat (3) tick();
    tests_run++; if (cyc1 !== 32'd10 || done1 !== 1'b1 || pass1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL done1_hold: got cyc=%0d done=%b pass=%b want 10,1,1", cyc1, done1, pass1);
    end
  endtask

  task automatic test_fail_hart1();
    start2 = 1; tick(); start2 = 0;
    wr_en2 = 2'b10; addr2 = {TH, 32'h0}; data2 = {32'h7, 32'h0}; tick(); wr_en2 = '0;
    tests_run++; if (done2 !== 1'b1 || pass2 !== 1'b0) begin tests_failed++;
      $display("FAIL fail2_flags: got done=%b pass=%b want 1,0", done2, pass2); end
    tests_run++; if (fh2 !== 1'b1 || fc2 !== 31'd3) begin tests_failed++;
      $display("FAIL fail2_fields: got hart=%0d code=%0d want 1,3", fh2, fc2); end
    tests_run++; if (hd2 !== 2'b10 || cyc2 !== 32'd1) begin tests_failed++;
      $display("FAIL fail2_hd: got hd=%b cyc=%0d want 10,1", hd2, cyc2); end
    wr_en2 = 2'b01; addr2 = {32'h0, TH}; data2 = {32'h0, 32'h1}; tick(); wr_en2 = '0;
    tests_run++; if ({done2, pass2, fh2, hd2} !== 5'b10110 || fc2 !== 31'd3) begin
      tests_failed++;
      $display("FAIL fail2_hold: got done=%b pass=%b hart=%0d hd=%b code=%0d want 1,0,1,10,3",
               done2, pass2, fh2, hd2, fc2);
    end
  endtask

  task automatic test_ignored_writes();
    // Store in IDLE does nothing.
    wr_en4 = 4'b0001; addr4 = {4{TH}}; data4 = {4{32'h1}}; tick(); wr_en4 = '0;
    tests_run++; if (busy4 !== 1'b0 || done4 !== 1'b0 || hd4 !== 4'b0) begin tests_failed++;
      $display("FAIL idle_write: got busy=%b done=%b hd=%b want 0,0,0000", busy4, done4, hd4);
    end
    // Restart from DONE with pass stores in the start cycle: stores ignored, results cleared.
    start2 = 1; wr_en2 = 2'b11; addr2 = {TH, TH}; data2 = {32'h1, 32'h1}; tick();
    start2 = 0; wr_en2 = '0;
    tests_run++; if (busy2 !== 1'b1 || hd2 !== 2'b00 || pass2 !== 1'b0) begin tests_failed++;
      $display("FAIL start_cycle_write: got busy=%b hd=%b pass=%b want 1,00,0",
               busy2, hd2, pass2); end
    tests_run++; if (fh2 !== 1'b0 || fc2 !== 31'd0 || cyc2 !== 32'd0 || done2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL restart_clear: got hart=%0d code=%0d cyc=%0d done=%b want 0,0,0,0",
               fh2, fc2, cyc2, done2);
    end
    // Even data to tohost, and pass to the wrong address.
    wr_en2 = 2'b11; addr2 = {TH + 32'd4, TH}; data2 = {32'h1, 32'h2}; tick(); wr_en2 = '0;
    tests_run++; if (busy2 !== 1'b1 || hd2 !== 2'b00 || cyc2 !== 32'd1) begin tests_failed++;
      $display("FAIL bad_writes: got busy=%b hd=%b cyc=%0d want 1,00,1", busy2, hd2, cyc2); end
    // Strobe low with otherwise valid store.
    wr_en2 = 2'b00; addr2 = {TH, TH}; data2 = {32'h1, 32'h1}; tick();
    tests_run++; if (busy2 !== 1'b1 || hd2 !== 2'b00) begin tests_failed++;
      $display("FAIL no_strobe: got busy=%b hd=%b want 1,00", busy2, hd2); end
  endtask

  task automatic test_same_cycle_fail();
    start4 = 1; tick(); start4 = 0;
    wr_en4 = 4'b1100; addr4 = {4{TH}}; data4 = {32'd9, 32'd5, 32'd0, 32'd0}; tick();
    wr_en4 = '0;
    tests_run++; if (done4 !== 1'b1 || pass4 !== 1'b0 || hd4 !== 4'b1100) begin tests_failed++;
      $display("FAIL multi_fail_flags: got done=%b pass=%b hd=%b want 1,0,1100",
               done4, pass4, hd4); end
    tests_run++; if (fh4 !== 2'd2 || fc4 !== 31'd2) begin tests_failed++;
      $display("FAIL multi_fail_lowest: got hart=%0d code=%0d want 2,2", fh4, fc4); end
  endtask

  task automatic test_all_pass();
    start4 = 1; tick(); start4 = 0;
    wr_en4 = 4'b0001; addr4 = {4{TH}}; data4 = {4{32'h1}}; tick();
    tests_run++; if (busy4 !== 1'b1 || hd4 !== 4'b0001) begin tests_failed++;
      $display("FAIL partial_pass: got busy=%b hd=%b want 1,0001", busy4, hd4); end
    wr_en4 = 4'b1111; tick(); wr_en4 = '0;
    tests_run++; if ({done4, pass4, busy4, hd4} !== 7'b1101111 || cyc4 !== 32'd2) begin
      tests_failed++;
      $display("FAIL all_pass: got done=%b pass=%b busy=%b hd=%b cyc=%0d want 1,1,0,1111,2",
               done4, pass4, busy4, hd4, cyc4);
    end
  endtask

  task automatic test_watchdog();
    start4 = 1; tick(); start4 = 0;
`ifdef TEST_MONITOR_WATCHDOG_EN
    repeat (49) tick();
    tests_run++; if (busy4 !== 1'b1 || cyc4 !== 32'd49) begin tests_failed++;
      $display("FAIL wd_pre: got busy=%b cyc=%0d want 1,49", busy4, cyc4); end
    tick();
    tests_run++; if ({done4, to4, pass4} !== 3'b110 || cyc4 !== 32'd50) begin tests_failed++;
      $display("FAIL wd_fire: got done=%b to=%b pass=%b cyc=%0d want 1,1,0,50",
               done4, to4, pass4, cyc4); end
`else
    repeat (1000) tick();
    tests_run++; if ({busy4, done4, to4} !== 3'b100 || cyc4 !== 32'd1000) begin tests_failed++;
      $display("FAIL no_wd: got busy=%b done=%b to=%b cyc=%0d want 1,0,0,1000",
               busy4, done4, to4, cyc4); end
`endif
  endtask

  task automatic test_reset_mid_run();
    start1 = 1; tick(); start1 = 0;
    repeat (3) tick();
    #3 rst_n = 1'b0;
    #1;
    tests_run++; if ({busy1, done1, pass1, hd1} !== 4'b0 || cyc1 !== 32'd0) begin
      tests_failed++;
      $display("FAIL async_reset1: got busy=%b done=%b pass=%b hd=%b cyc=%0d want all 0",
               busy1, done1, pass1, hd1, cyc1);
    end
    tests_run++; if ({busy4, done4, to4, hd4} !== 7'b0 || cyc4 !== 32'd0) begin
      tests_failed++;
      $display("FAIL async_reset4: got busy=%b done=%b to=%b hd=%b cyc=%0d want all 0",
               busy4, done4, to4, hd4, cyc4);
    end
    #1 rst_n = 1'b1;
    tick();
    tests_run++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin tests_failed++;
      $display("FAIL post_reset_idle: got busy=%b done=%b want 0,0", busy1, done1); end
    start1 = 1; tick(); start1 = 0;
    tick();
    wr_en1 = 1; addr1 = TH; data1 = 32'h1; tick(); wr_en1 = 0;
    tests_run++; if ({done1, pass1} !== 2'b11 || cyc1 !== 32'd2) begin tests_failed++;
      $display("FAIL rerun_after_reset: got done=%b pass=%b cyc=%0d want 1,1,2",
               done1, pass1, cyc1); end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_fail_hart1();
    test_ignored_writes();
    test_same_cycle_fail();
    test_all_pass();
    test_watchdog();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got stall want completion");
    $fatal(1, "bench timeout");
  end

endmodule
